// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/stall controller and forwarding unit.
// State codes, register constants and pipeline control bundles.
package hazard_pkg;

    localparam logic ST_RUN     = 1'b0;
    localparam logic ST_MD_WAIT = 1'b1;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_bubble;
        logic ex_mem_bubble;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_RESET = '{
        pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
        id_ex_write: 1'b1, id_ex_bubble: 1'b1, ex_mem_bubble: 1'b1
    };

    // Mul/div holds the front of the pipe and drains EX/MEM.
    localparam hz_ctrl_t CTRL_MD = '{
        pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
        id_ex_write: 1'b0, id_ex_bubble: 1'b0, ex_mem_bubble: 1'b1
    };

    localparam hz_ctrl_t CTRL_BR = '{
        pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
        id_ex_write: 1'b1, id_ex_bubble: 1'b1, ex_mem_bubble: 1'b0
    };

    localparam hz_ctrl_t CTRL_LU = '{
        pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
        id_ex_write: 1'b1, id_ex_bubble: 1'b1, ex_mem_bubble: 1'b0
    };

    localparam hz_ctrl_t CTRL_RUN = '{
        pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
        id_ex_write: 1'b1, id_ex_bubble: 1'b0, ex_mem_bubble: 1'b0
    };

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Load-use hazard detector: a load in EX whose destination is read in ID.
// Purely combinational; $zero is never a real dependency.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [4:0] if_id_rs,
    input  logic [4:0] if_id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       id_ex_memRead,
    input  logic [4:0] id_ex_rt,
    output logic       lu
);

    logic hit_rs;
    logic hit_rt;

    assign hit_rs = id_uses_rs && (id_ex_rt == if_id_rs);
    assign hit_rt = id_uses_rt && (id_ex_rt == if_id_rt);

    assign lu = id_ex_memRead && (id_ex_rt != REG_ZERO) && (hit_rs || hit_rt);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and
// mul/div occupancy, plus saturating stall/flush counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_ex_memRead,
    input  logic [4:0]       id_ex_rt,
    input  logic             ex_branch_taken,
    input  logic             ex_muldiv,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic             muldiv_start,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [7:0] MD_INIT = 8'(MD_LATENCY - 1);

    logic       state;
    logic       state_nxt;
    logic [7:0] md_cnt;
    logic [7:0] md_cnt_nxt;
    logic       stall_md;
    logic       lu;
    logic       sel_md;
    logic       sel_br;
    logic       sel_lu;
    hz_ctrl_t   ctrl;

    load_use_detect u_lu (
        .if_id_rs      (if_id_rs),
        .if_id_rt      (if_id_rt),
        .id_uses_rs    (id_uses_rs),
        .id_uses_rt    (id_uses_rt),
        .id_ex_memRead (id_ex_memRead),
        .id_ex_rt      (id_ex_rt),
        .lu            (lu)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_RUN;
            md_cnt <= 8'd0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        unique case (state)
            ST_RUN: begin
                if (ex_muldiv) begin
                    state_nxt  = ST_MD_WAIT;
                    md_cnt_nxt = MD_INIT;
                end
            end
            ST_MD_WAIT: begin
                if (md_cnt != 8'd0) begin
                    md_cnt_nxt = md_cnt - 8'd1;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
        endcase
    end

    always_comb begin
        muldiv_start = 1'b0;
        stall_md     = 1'b0;
        unique case (state)
            ST_RUN: begin
                muldiv_start = ex_muldiv;
                stall_md     = ex_muldiv;
            end
            ST_MD_WAIT: begin
                stall_md = (md_cnt != 8'd0);
            end
        endcase
        if (rst) begin
            muldiv_start = 1'b0;
            stall_md     = 1'b0;
        end
    end

    // Selects are made mutually exclusive so the decoder encodes priority.
    assign sel_md = !rst && stall_md;
    assign sel_br = !rst && !stall_md && ex_branch_taken;
    assign sel_lu = !rst && !stall_md && !ex_branch_taken && lu;

    always_comb begin
        ctrl = CTRL_RUN;
        unique case (1'b1)
            rst:     ctrl = CTRL_RESET;
            sel_md:  ctrl = CTRL_MD;
            sel_br:  ctrl = CTRL_BR;
            sel_lu:  ctrl = CTRL_LU;
            default: ctrl = CTRL_RUN;
        endcase
    end

    assign pc_write      = ctrl.pc_write;
    assign if_id_write   = ctrl.if_id_write;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_write   = ctrl.id_ex_write;
    assign id_ex_bubble  = ctrl.id_ex_bubble;
    assign ex_mem_bubble = ctrl.ex_mem_bubble;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!ctrl.pc_write && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (ctrl.if_id_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed steps then random traffic,
// checked each cycle against a cycle-timeline reference model.
module tb_hazard_ctrl;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] if_id_rs;
    logic [4:0] if_id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_ex_memRead;
    logic [4:0] id_ex_rt;
    logic       ex_branch_taken;
    logic       ex_muldiv;

    logic        pc_write, if_id_write, if_id_flush, id_ex_write;
    logic        id_ex_bubble, ex_mem_bubble, muldiv_start;
    logic [15:0] stall_cnt, flush_cnt;

    logic       s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_write;
    logic       s_id_ex_bubble, s_ex_mem_bubble, s_muldiv_start;
    logic [3:0] s_stall_cnt, s_flush_cnt;

    int n_vec = 0;
    int n_err = 0;

    int cyc = 0;
    int md_t0 = 0;
    bit md_act = 1'b0;
    bit cnt_known = 1'b0;
    int m_stall = 0, m_flush = 0, s_stall = 0, s_flush = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_LATENCY(LAT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_ex_memRead(id_ex_memRead), .id_ex_rt(id_ex_rt),
        .ex_branch_taken(ex_branch_taken), .ex_muldiv(ex_muldiv),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_write(id_ex_write),
        .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
        .muldiv_start(muldiv_start),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.MD_LATENCY(LAT), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_ex_memRead(id_ex_memRead), .id_ex_rt(id_ex_rt),
        .ex_branch_taken(ex_branch_taken), .ex_muldiv(ex_muldiv),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write),
        .if_id_flush(s_if_id_flush), .id_ex_write(s_id_ex_write),
        .id_ex_bubble(s_id_ex_bubble), .ex_mem_bubble(s_ex_mem_bubble),
        .muldiv_start(s_muldiv_start),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    // One cycle: predict, compare outputs, clock, advance the model.
    task automatic tick();
        bit lu, st, smd;
        bit e_pc, e_ifw, e_fl, e_idw, e_bub, e_exm;
        #1;
        lu = id_ex_memRead && (id_ex_rt != 0) &&
             ((id_uses_rs && id_ex_rt == if_id_rs) ||
              (id_uses_rt && id_ex_rt == if_id_rt));
        st  = !md_act && ex_muldiv;
        smd = st || (md_act && cyc < md_t0 + LAT);
        if (rst) begin
            st = 1'b0;
            {e_pc, e_ifw, e_fl, e_idw, e_bub, e_exm} = 6'b001111;
        end else if (smd) begin
            {e_pc, e_ifw, e_fl, e_idw, e_bub, e_exm} = 6'b000001;
        end else if (ex_branch_taken) begin
            {e_pc, e_ifw, e_fl, e_idw, e_bub, e_exm} = 6'b111110;
        end else if (lu) begin
            {e_pc, e_ifw, e_fl, e_idw, e_bub, e_exm} = 6'b000110;
        end else begin
            {e_pc, e_ifw, e_fl, e_idw, e_bub, e_exm} = 6'b110100;
        end
        chk("pc_write", 32'(pc_write), 32'(e_pc));
        chk("if_id_write", 32'(if_id_write), 32'(e_ifw));
        chk("if_id_flush", 32'(if_id_flush), 32'(e_fl));
        chk("id_ex_write", 32'(id_ex_write), 32'(e_idw));
        chk("id_ex_bubble", 32'(id_ex_bubble), 32'(e_bub));
        chk("ex_mem_bubble", 32'(ex_mem_bubble), 32'(e_exm));
        chk("muldiv_start", 32'(muldiv_start), 32'(st));
        chk("s_pc_write", 32'(s_pc_write), 32'(e_pc));
        if (cnt_known) begin
            chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
            chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
            chk("s_stall_cnt", 32'(s_stall_cnt), 32'(s_stall));
            chk("s_flush_cnt", 32'(s_flush_cnt), 32'(s_flush));
        end
        @(posedge clk);
        if (rst) begin
            md_act = 1'b0;
            m_stall = 0; m_flush = 0; s_stall = 0; s_flush = 0;
            cnt_known = 1'b1;
        end else begin
            if (!e_pc) begin
                m_stall = sat(m_stall, 65535);
                s_stall = sat(s_stall, 15);
            end
            if (e_fl) begin
                m_flush = sat(m_flush, 65535);
                s_flush = sat(s_flush, 15);
            end
            if (md_act && cyc == md_t0 + LAT) begin
                md_act = 1'b0;
            end else if (!md_act && ex_muldiv) begin
                md_act = 1'b1;
                md_t0  = cyc;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_id_rs = 5'd0; if_id_rt = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_ex_memRead = 1'b0; id_ex_rt = 5'd0;
        ex_branch_taken = 1'b0; ex_muldiv = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rt, input logic use_rs);
        id_ex_memRead = 1'b1; id_ex_rt = rt;
        if_id_rs = 5'd8; id_uses_rs = use_rs;
        if_id_rt = 5'd3; id_uses_rt = 1'b0;
    endtask

    initial begin
        int base;
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);

        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rel_stall_cnt", 32'(stall_cnt), 32'd0);

        set_lu(5'd8, 1'b1);
        tick();
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        idle_inputs();
        tick();
        set_lu(5'd0, 1'b1);
        tick();
        set_lu(5'd8, 1'b0);
        tick();
        chk("lu_neg_stall_cnt", 32'(stall_cnt), 32'd1);

        set_lu(5'd8, 1'b1);
        ex_branch_taken = 1'b1;
        tick();
        chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("br_stall_cnt", 32'(stall_cnt), 32'd1);
        idle_inputs();
        tick();

        base = int'(stall_cnt);
        ex_muldiv = 1'b1;
        repeat (6) tick();
        ex_muldiv = 1'b0;
        repeat (4) tick();
        chk("md_stalls", 32'(int'(stall_cnt) - base), 32'd8);
        tick();

        ex_muldiv = 1'b1;
        tick();
        ex_muldiv = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();

        set_lu(5'd8, 1'b1);
        repeat (20) tick();
        chk("sat_s_stall_cnt", 32'(s_stall_cnt), 32'd15);
        chk("nosat_stall_cnt", 32'(stall_cnt), 32'd20);
        idle_inputs();
        tick();

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            if_id_rs = 5'($urandom_range(0, 3));
            if_id_rt = 5'($urandom_range(0, 3));
            id_uses_rs = 1'($urandom);
            id_uses_rt = 1'($urandom);
            id_ex_memRead = 1'($urandom);
            id_ex_rt = 5'($urandom_range(0, 3));
            ex_muldiv = ($urandom_range(0, 7) == 0);
            ex_branch_taken = ($urandom_range(0, 3) == 0);
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        repeat (LAT + 2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and stall controller for the 5-stage MIPS core; sits beside the forwarding unit and drives the write-enable and flush controls of PC, IF/ID, ID/EX and EX/MEM.
Handles three hazards:
- load-use stalls, detected combinationally;
- taken-branch flushes;
- multi-cycle multiply/divide occupancy, sequenced by an FSM with a latency counter.
Also keeps saturating stall and flush performance counters.

Parameters:
MD_LATENCY, 4, cycles the mul/div unit needs after start; legal range 1..255.
CNT_W, 16, width of the performance counters.

Ports:
clk  input  1  single core clock
rst  input  1  synchronous, active-high reset
if_id_rs  input  5  rs field of the instruction in ID
if_id_rt  input  5  rt field of the instruction in ID
id_uses_rs  input  1  ID instruction reads rs
id_uses_rt  input  1  ID instruction reads rt
id_ex_memRead  input  1  instruction in EX is a load
id_ex_rt  input  5  destination register of the load in EX
ex_branch_taken  input  1  branch/jump in EX resolved taken
ex_muldiv  input  1  instruction in EX is mult/div
pc_write  output  1  PC load enable
if_id_write  output  1  IF/ID load enable
if_id_flush  output  1  IF/ID cleared to NOP
id_ex_write  output  1  ID/EX load enable
id_ex_bubble  output  1  ID/EX loaded with NOP
ex_mem_bubble  output  1  EX/MEM loaded with NOP
muldiv_start  output  1  one-cycle start pulse to the mul/div unit
stall_cnt  output  CNT_W  cycles with pc_write=0 (saturating)
flush_cnt  output  CNT_W  taken-branch flushes (saturating)

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- While rst=1:
  - pc_write=0, if_id_write=0, id_ex_write=1;
  - if_id_flush=1, id_ex_bubble=1, ex_mem_bubble=1, muldiv_start=0.
  - On the next edge: state=RUN, md_cnt=0, stall_cnt=0, flush_cnt=0.
  - A reset asserted while in MD_WAIT aborts the wait. The mul/div unit shares rst.
- FSM states: RUN and MD_WAIT. md_cnt is 8 bits.
- RUN:
  - If ex_muldiv=1: muldiv_start=1, stall_md=1. Next state MD_WAIT, md_cnt<=MD_LATENCY-1.
  - Otherwise remain in RUN.
- MD_WAIT:
  - If md_cnt!=0: stall_md=1, md_cnt<=md_cnt-1.
  - If md_cnt==0 (release cycle): stall_md=0, next state RUN.
  - ex_muldiv still high in MD_WAIT never retriggers.
  - A mul/div therefore occupies EX for MD_LATENCY+1 cycles.
  - Back-to-back mul/div: the second starts in the first RUN cycle after release.
- Load-use detection:
  - lu = id_ex_memRead && id_ex_rt!=0 && ((id_uses_rs && id_ex_rt==if_id_rs) || (id_uses_rt && id_ex_rt==if_id_rt)).
  - Purely combinational. The stall naturally lasts one cycle.
- Output priority, evaluated per cycle (highest first):
  1. stall_md: pc_write=0, if_id_write=0, id_ex_write=0, id_ex_bubble=0, if_id_flush=0, ex_mem_bubble=1.
  2. ex_branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_write=1, id_ex_bubble=1, ex_mem_bubble=0. This overrides lu.
  3. lu: pc_write=0, if_id_write=0, id_ex_write=1, id_ex_bubble=1, if_id_flush=0, ex_mem_bubble=0.
  4. Default: all write enables 1, all flush/bubble outputs 0.
- ex_branch_taken and ex_muldiv are never both 1. If both are 1, ex_muldiv wins.
- muldiv_start is high for exactly one cycle per mul/div.
- All outputs except the counters are combinational from state, md_cnt and inputs. No added latency.
- Performance counters:
  - stall_cnt increments on each non-reset cycle with pc_write=0.
  - flush_cnt increments on each non-reset cycle with if_id_flush=1.
  - Both saturate at all-ones.

Decomposition:
- Shared package hazard_pkg holds:
  - state encoding localparams ST_RUN=1'b0 and ST_MD_WAIT=1'b1;
  - REG_ZERO=5'd0;
  - the forwarding select codes FWD_NONE=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, shared with the forwarding unit.
- One sub-module, load_use_detect: pure combinational producer of lu.

Test Plan:
- Reset:
  - Hold rst=1 for 3 cycles, then release → during reset pc_write=0, if_id_flush=1, bubbles=1. First cycle after release: all enables 1, stall_cnt=0.
- Load-use:
  - id_ex_memRead=1, id_ex_rt=8, if_id_rs=8, id_uses_rs=1 → one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1. stall_cnt becomes 1.
  - Repeat with id_ex_rt=0 → no stall.
  - Repeat with id_uses_rs=0 → no stall.
- Branch overrides load-use:
  - lu true together with ex_branch_taken=1 → if_id_flush=1, id_ex_bubble=1, pc_write=1. flush_cnt increments by 1, stall_cnt unchanged.
- Mul/div, MD_LATENCY=4:
  - Hold ex_muldiv=1 → muldiv_start high for 1 cycle only.
  - pc_write=0 and ex_mem_bubble=1 for 4 cycles, then the release cycle has all enables 1.
  - Follow with a second mul/div → a second start pulse exactly 1 cycle after release. stall_cnt=8 after both.
- Mid-wait reset and saturation:
  - Assert rst at md_cnt=2 → next cycle state RUN, no start pulse, pc_write=0 during rst.
  - With CNT_W=4, run 20 load-use stalls → stall_cnt holds at 15.
